// File: rtl/dsp_fe_lane_aligner_if.sv
// Bus bundle between the ADC deserializer/config side and the lane aligner.
// The master drives DES words, skew and training controls. The slave (the
// aligner) returns the transposed data and the training status.
interface dsp_fe_lane_aligner_if #(
    parameter int ADC_WIDTH     = 6,
    parameter int DES_OUT_WIDTH = 4,
    parameter int MAX_SKEW      = 3
);
    localparam int SKEW_W = $clog2(MAX_SKEW + 1);
    localparam int SLIP_W = (DES_OUT_WIDTH > 1) ? $clog2(DES_OUT_WIDTH) : 1;

    logic [ADC_WIDTH-1:0][DES_OUT_WIDTH-1:0] i_dat_ad_lane;
    logic [ADC_WIDTH-1:0][SKEW_W-1:0]        i_skew_cfg;
    logic                                    i_train_start;
    logic [DES_OUT_WIDTH-1:0]                i_train_pattern;
    logic [DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0] o_dat_da_lane;
    logic [ADC_WIDTH-1:0][SLIP_W-1:0]        o_slip;
    logic [ADC_WIDTH-1:0]                    o_lane_locked;
    logic                                    o_locked;
    logic                                    o_fail;

    modport master (
        output i_dat_ad_lane, i_skew_cfg, i_train_start, i_train_pattern,
        input  o_dat_da_lane, o_slip, o_lane_locked, o_locked, o_fail
    );

    modport slave (
        input  i_dat_ad_lane, i_skew_cfg, i_train_start, i_train_pattern,
        output o_dat_da_lane, o_slip, o_lane_locked, o_locked, o_fail
    );
endinterface

// File: rtl/dsp_fe_lane_aligner.sv
// Lane aligner between the ADC deserializer and the LUT stage.
// Each lane goes through a retime stage, a bitslip selector, a skew delay line
// and an output register. The output register transposes the lanes to
// sample-major order. A training FSM searches each lane's bitslip against a
// known word.
module dsp_fe_lane_aligner #(
    parameter int ADC_WIDTH     = 6,
    parameter int DES_OUT_WIDTH = 4,
    parameter int MAX_SKEW      = 3,
    parameter int TRAIN_MATCH   = 8,
    parameter int TRAIN_TIMEOUT = 256
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    input logic                  i_en,
    dsp_fe_lane_aligner_if.slave bus
);
    localparam int D       = DES_OUT_WIDTH;
    localparam int SKEW_W  = $clog2(MAX_SKEW + 1);
    localparam int NTAP    = 1 << SKEW_W;
    localparam int SLIP_W  = (D > 1) ? $clog2(D) : 1;
    localparam int MATCH_W = $clog2(TRAIN_MATCH + 1);
    localparam int TOUT_W  = $clog2(TRAIN_TIMEOUT);

    typedef enum logic [1:0] {IDLE = 2'd0, TRAIN = 2'd1, LOCKED = 2'd2, FAIL = 2'd3} state_t;

    state_t state_q, state_d;

    logic [D-1:0]   r_q    [ADC_WIDTH];
    logic [D-1:0]   p_q    [ADC_WIDTH];
    logic [D-1:0]   s_q    [ADC_WIDTH];
    logic [D-1:0]   s_d    [ADC_WIDTH];
    logic [2*D-1:0] cat    [ADC_WIDTH];
    logic [D-1:0]   dly_q  [ADC_WIDTH][MAX_SKEW];
    logic [D-1:0]   tap    [ADC_WIDTH][NTAP];
    logic [D-1:0]   selTap [ADC_WIDTH];

    logic [D-1:0][ADC_WIDTH-1:0]     datOut_q;
    logic [ADC_WIDTH-1:0][SLIP_W-1:0]  slip_q, slip_d;
    logic [ADC_WIDTH-1:0]              laneLock_q, laneLock_d;
    logic [ADC_WIDTH-1:0][MATCH_W-1:0] matchCnt_q, matchCnt_d;
    logic [ADC_WIDTH-1:0][1:0]         settleCnt_q, settleCnt_d;
    logic [TOUT_W-1:0]                 timeoutCnt_q, timeoutCnt_d;

    // Bitslip window: choose D bits from {previous, current} word, offset by slip.
    always_comb begin
        for (int i = 0; i < ADC_WIDTH; i++) begin
            cat[i] = {p_q[i], r_q[i]};
            s_d[i] = cat[i][slip_q[i] +: D];
        end
    end

    // Tap table: tap 0 is undelayed. Indices above MAX_SKEW repeat the deepest
    // stage, so a large config value clamps instead of reading undefined data.
    for (genvar gi = 0; gi < ADC_WIDTH; gi++) begin : g_lane
        for (genvar gk = 0; gk < NTAP; gk++) begin : g_tap
            if (gk == 0) begin : g_direct
                assign tap[gi][gk] = s_q[gi];
            end else if (gk <= MAX_SKEW) begin : g_delayed
                assign tap[gi][gk] = dly_q[gi][gk-1];
            end else begin : g_clamped
                assign tap[gi][gk] = dly_q[gi][MAX_SKEW-1];
            end
        end
    end

    // Per-lane skew tap selection from the live configuration.
    always_comb begin
        for (int i = 0; i < ADC_WIDTH; i++) begin
            selTap[i] = tap[i][bus.i_skew_cfg[i]];
        end
    end

    // Retime, slip and skew pipeline. It advances only when enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ADC_WIDTH; i++) begin
                r_q[i] <= '0;
                p_q[i] <= '0;
                s_q[i] <= '0;
                for (int k = 0; k < MAX_SKEW; k++) begin
                    dly_q[i][k] <= '0;
                end
            end
        end else if (i_en) begin
            for (int i = 0; i < ADC_WIDTH; i++) begin
                r_q[i]      <= bus.i_dat_ad_lane[i];
                p_q[i]      <= r_q[i];
                s_q[i]      <= s_d[i];
                dly_q[i][0] <= s_q[i];
                for (int k = 1; k < MAX_SKEW; k++) begin
                    dly_q[i][k] <= dly_q[i][k-1];
                end
            end
        end
    end

    // Output register: transpose from lane-major to sample-major order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            datOut_q <= '0;
        end else if (i_en) begin
            for (int i = 0; i < ADC_WIDTH; i++) begin
                for (int j = 0; j < D; j++) begin
                    datOut_q[j][i] <= selTap[i][j];
                end
            end
        end
    end

    // Training state and per-lane search registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            slip_q       <= '0;
            laneLock_q   <= '0;
            matchCnt_q   <= '0;
            settleCnt_q  <= '0;
            timeoutCnt_q <= '0;
        end else if (i_en) begin
            state_q      <= state_d;
            slip_q       <= slip_d;
            laneLock_q   <= laneLock_d;
            matchCnt_q   <= matchCnt_d;
            settleCnt_q  <= settleCnt_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    // Training next-state. A start pulse restarts from any state. After each
    // slip change, the lane waits two cycles so the new alignment can reach s.
    always_comb begin
        state_d      = state_q;
        slip_d       = slip_q;
        laneLock_d   = laneLock_q;
        matchCnt_d   = matchCnt_q;
        settleCnt_d  = settleCnt_q;
        timeoutCnt_d = timeoutCnt_q;
        if (bus.i_train_start) begin
            state_d      = TRAIN;
            slip_d       = '0;
            laneLock_d   = '0;
            matchCnt_d   = '0;
            timeoutCnt_d = '0;
            for (int i = 0; i < ADC_WIDTH; i++) begin
                settleCnt_d[i] = 2'd2;
            end
        end else if (state_q == TRAIN) begin
            for (int i = 0; i < ADC_WIDTH; i++) begin
                if (!laneLock_q[i]) begin
                    if (settleCnt_q[i] != 2'd0) begin
                        settleCnt_d[i] = settleCnt_q[i] - 2'd1;
                    end else if (s_q[i] == bus.i_train_pattern) begin
                        matchCnt_d[i] = matchCnt_q[i] + MATCH_W'(1);
                        if (matchCnt_q[i] == MATCH_W'(TRAIN_MATCH - 1)) begin
                            laneLock_d[i] = 1'b1;
                        end
                    end else begin
                        matchCnt_d[i]  = '0;
                        settleCnt_d[i] = 2'd2;
                        slip_d[i]      = (slip_q[i] == SLIP_W'(D - 1)) ? '0
                                                                       : slip_q[i] + SLIP_W'(1);
                    end
                end
            end
            if (&laneLock_d) begin
                state_d = LOCKED;
            end else if (timeoutCnt_q == TOUT_W'(TRAIN_TIMEOUT - 1)) begin
                state_d = FAIL;
            end else begin
                timeoutCnt_d = timeoutCnt_q + TOUT_W'(1);
            end
        end
    end

    assign bus.o_dat_da_lane = datOut_q;
    assign bus.o_slip        = slip_q;
    assign bus.o_lane_locked = laneLock_q;
    assign bus.o_locked      = (state_q == LOCKED);
    assign bus.o_fail        = (state_q == FAIL);

endmodule
